pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have ports: clk  in  1  sole clock; rst  in  1  reset, synchronous, active-high.
REQ-002 The block SHALL have ports: id_rs1_addr / id_rs2_addr  in  `GPR_ADDR_SPACE  decode-stage source registers; id_rs1_re / id_rs2_re  in  1  source read enables.
REQ-003 The block SHALL have ports: id_fence  in  1  FENCE.I in decode.
REQ-004 The block SHALL have ports: id_exe_rd_addr  in  `GPR_ADDR_SPACE  destination of the EXE instruction; id_exe_rd_we  in  1  EXE writes rd; id_exe_mem_re  in  1  EXE instruction is a load.
REQ-005 The block SHALL have ports: exe_redirect  in  1  branch/jump taken in EXE; exe_md_start  in  1  multi-cycle MUL/DIV in EXE; exe_md_done  in  1  MUL/DIV result valid.
REQ-006 The block SHALL have ports: mem_req  in  1  data-memory access in MEM; mem_ready  in  1  access completes this cycle.
REQ-007 The block SHALL have stall outputs, each out 1: pc_stall, if_id_stall, id_exe_stall, exe_mem_stall, mem_wb_stall.
REQ-008 The block SHALL have flush/bubble outputs, each out 1: if_id_flush, id_exe_flush, exe_mem_flush.
REQ-009 The block SHALL have port ctrl_state  out  2  current FSM state.

Function
REQ-010 States SHALL be RUN=0, MEM_WAIT=1, EXE_BUSY=2, DRAIN=3; state SHALL be registered, and outputs SHALL be combinational from state and inputs.
REQ-011 Priority each cycle SHALL be: memory wait > MUL/DIV busy > redirect > fence > load-use.
REQ-012 MEM_WAIT condition (mem_req & ~mem_ready) SHALL assert all five stalls with no flush; in RUN the FSM enters MEM_WAIT next cycle; on mem_ready it returns to the entry state (RUN or EXE_BUSY), tracked by a 1-bit return register.
REQ-013 In RUN, exe_md_start & ~exe_md_done SHALL assert pc/if_id/id_exe stalls plus exe_mem_flush and enter EXE_BUSY; exe_md_start & exe_md_done in the same cycle SHALL cause no stall.
REQ-014 EXE_BUSY SHALL hold the same outputs until exe_md_done, then return to RUN with no stall that cycle.
REQ-015 exe_redirect in RUN with no higher-priority condition SHALL assert if_id_flush and id_exe_flush for exactly one cycle; redirect during any stall SHALL be deferred and acted on in the first unstalled cycle (the input stays held).
REQ-016 Load-use (id_exe_mem_re & id_exe_rd_we & rd!=0 & ((id_rs1_re & rs1==rd) | (id_rs2_re & rs2==rd))) SHALL assert pc_stall, if_id_stall and id_exe_flush for one cycle; it SHALL be suppressed by redirect in the same cycle.
REQ-017 id_fence in RUN SHALL enter DRAIN with a 2-bit drain counter loaded to 3.
REQ-018 DRAIN SHALL assert pc_stall, if_id_stall and id_exe_flush; the counter SHALL decrement on each cycle with no MEM_WAIT condition; at 0 the FSM SHALL assert if_id_flush for one cycle and return to RUN.
REQ-019 A MEM_WAIT condition in DRAIN SHALL stall all stages and freeze the counter.
REQ-020 A stage SHALL never be stalled and flushed in the same cycle; flush wins.

Reset
REQ-021 While rst is high, state SHALL go to RUN, the drain counter and return register SHALL go to 0, all stalls SHALL be 0, if_id_flush and id_exe_flush SHALL be 1, and exe_mem_flush SHALL be 0.
REQ-022 Reset mid-operation (any state) SHALL take effect on the next clk edge without completing a drain or wait.

Configuration
REQ-023 With PIPE_CTRL_PERF_EN defined, the block SHALL add outputs stall_cnt[31:0] and flush_cnt[31:0].
REQ-024 Under PIPE_CTRL_PERF_EN, stall_cnt SHALL count cycles with pc_stall=1, and flush_cnt SHALL count cycles with if_id_flush=1; both SHALL be cleared by rst and SHALL wrap at 2^32.
REQ-025 Without PIPE_CTRL_PERF_EN, these ports and counters SHALL be absent and the remaining behaviour unchanged.

Verification
REQ-026 Load-use: EXE load with rd=5, ID rs1=5 -> one cycle of pc_stall=1, if_id_stall=1, id_exe_flush=1; next cycle all 0.
REQ-027 Memory wait: mem_req=1 with mem_ready=0 for 4 cycles -> all stalls=1 for 4 cycles, ctrl_state=1, then RUN.
REQ-028 MUL/DIV busy: exe_md_start=1 with done after 6 cycles -> EXE_BUSY for 6 cycles with exe_mem_flush=1; start & done in the same cycle -> no stall.
REQ-029 Redirect during MEM_WAIT: exe_redirect held through 3 wait cycles -> flushes only in the first RUN cycle, for exactly 1 cycle.
REQ-030 Fence with a mem wait of 2 cycles inserted -> DRAIN lasts 3+2 cycles, then if_id_flush=1 for one cycle; rst asserted mid-DRAIN -> RUN next cycle, counter 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stalls/flushes for memory waits, MUL/DIV, redirects, FENCE.I drain, load-use.
// Optional performance counters (stall_cnt/flush_cnt) are built when PIPE_CTRL_PERF_EN is defined.
`ifndef GPR_ADDR_SPACE
`define GPR_ADDR_SPACE 4:0
`endif

module pipe_ctrl (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [`GPR_ADDR_SPACE] id_rs1_addr,
  input  logic [`GPR_ADDR_SPACE] id_rs2_addr,
  input  logic                   id_rs1_re,
  input  logic                   id_rs2_re,
  input  logic                   id_fence,
  input  logic [`GPR_ADDR_SPACE] id_exe_rd_addr,
  input  logic                   id_exe_rd_we,
  input  logic                   id_exe_mem_re,
  input  logic                   exe_redirect,
  input  logic                   exe_md_start,
  input  logic                   exe_md_done,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_stall,
  output logic                   if_id_stall,
  output logic                   id_exe_stall,
  output logic                   exe_mem_stall,
  output logic                   mem_wb_stall,
  output logic                   if_id_flush,
  output logic                   id_exe_flush,
  output logic                   exe_mem_flush,
  output logic [1:0]             ctrl_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]            stall_cnt,
  output logic [31:0]            flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    EXE_BUSY = 2'd2,
    DRAIN    = 2'd3
  } state_e;

  state_e     state_q, state_d, eff_state;
  logic       ret_q, ret_d;
  logic [1:0] cnt_q, cnt_d;
  logic       mem_wait, load_use;
  logic [4:0] stall_raw;  // {pc, if_id, id_exe, exe_mem, mem_wb}
  logic [2:0] flush_raw;  // {if_id, id_exe, exe_mem}

  assign mem_wait = mem_req & ~mem_ready;
  assign load_use = id_exe_mem_re & id_exe_rd_we & (id_exe_rd_addr != '0) &
                    ((id_rs1_re & (id_rs1_addr == id_exe_rd_addr)) |
                     (id_rs2_re & (id_rs2_addr == id_exe_rd_addr)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      ret_q   <= 1'b0;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    cnt_d     = cnt_q;
    stall_raw = 5'b00000;
    flush_raw = 3'b000;
    // A completing wait or MUL/DIV is an unstalled cycle: evaluate it as the state being resumed.
    eff_state = state_q;
    if (state_q == MEM_WAIT) eff_state = ret_q ? EXE_BUSY : RUN;
    if ((eff_state == EXE_BUSY) && exe_md_done) eff_state = RUN;

    if (rst) begin
      flush_raw = 3'b110;
    end else if (mem_wait) begin
      stall_raw = 5'b11111;
      if (state_q != DRAIN) begin
        state_d = MEM_WAIT;
        ret_d   = (eff_state == EXE_BUSY);
      end
    end else begin
      case (eff_state)
        RUN: begin
          state_d = RUN;
          if (exe_md_start && !exe_md_done) begin
            stall_raw = 5'b11100;
            flush_raw = 3'b001;
            state_d   = EXE_BUSY;
          end else if (exe_redirect) begin
            flush_raw = 3'b110;
          end else if (id_fence) begin
            state_d = DRAIN;
            cnt_d   = 2'd3;
          end else if (load_use) begin
            stall_raw = 5'b11000;
            flush_raw = 3'b010;
          end
        end
        EXE_BUSY: begin
          stall_raw = 5'b11100;
          flush_raw = 3'b001;
          state_d   = EXE_BUSY;
        end
        DRAIN: begin
          if (cnt_q == 2'd0) begin
            flush_raw = 3'b100;
            state_d   = RUN;
          end else begin
            stall_raw = 5'b11000;
            flush_raw = 3'b010;
            cnt_d     = cnt_q - 2'd1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // Flush takes precedence over stall on the same pipeline register.
  assign pc_stall      = stall_raw[4];
  assign if_id_stall   = stall_raw[3] & ~flush_raw[2];
  assign id_exe_stall  = stall_raw[2] & ~flush_raw[1];
  assign exe_mem_stall = stall_raw[1] & ~flush_raw[0];
  assign mem_wb_stall  = stall_raw[0];
  assign if_id_flush   = flush_raw[2];
  assign id_exe_flush  = flush_raw[1];
  assign exe_mem_flush = flush_raw[0];
  assign ctrl_state    = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      if (pc_stall)    stall_cnt_q <= stall_cnt_q + 32'd1;
      if (if_id_flush) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  // Counters are not present in this build.
`endif

endmodule
